uart_rx_ctrl: RTL and testbench

- Sequencing controller for the byte-level UART receive datapath: arms and disarms it, tracks each frame, checks the stop bit, supervises against a stuck datapath, and buffers completed bytes in a small FIFO with a valid/ready consumer interface.
- Sits between the receive datapath and the byte consumer (command parser / loopback logic).
- Single clock domain; the raw line is synchronised internally.

---
 rtl/uart_rx_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequencing controller for the UART byte receive datapath.
// Arms the datapath, tracks each frame, checks the stop bit, supervises a
// stuck datapath with a timeout, and buffers completed bytes in a small FIFO
// with a valid/ready consumer port.
// Optional build macro UART_RX_CTRL_STATS_EN adds saturating frame counters.
//
// Consumer handshake: a byte transfers on any rising clk edge where
// dout_valid && dout_ready; dout_valid never depends on dout_ready, and
// dout holds its last value while dout_valid is low.
module uart_rx_ctrl #(
    parameter int BIT_CLKS     = 434,
    parameter int FIFO_DEPTH   = 4,
    parameter int TIMEOUT_BITS = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          rx_line,
    input  logic                          rx_busy,
    input  logic [7:0]                    rx_data,
    output logic                          rx_ena,
    output logic [7:0]                    dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          err_frame,
    output logic                          err_overrun,
    output logic                          err_timeout,
    input  logic                          err_clr,
`ifdef UART_RX_CTRL_STATS_EN
    output logic [15:0]                   frames_ok,
    output logic [15:0]                   frames_bad,
`endif
    output logic [2:0]                    dbg_state
);

    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int BT_W     = $clog2(BIT_CLKS);
    localparam int TO_LIMIT = TIMEOUT_BITS * BIT_CLKS;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);

    localparam logic [BT_W-1:0]  BT_HALF_M1 = BT_W'(BIT_CLKS / 2 - 1);
    localparam logic [BT_W-1:0]  BT_LAST    = BT_W'(BIT_CLKS - 1);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TO_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_RECV   = 3'd2,
        ST_STOP   = 3'd3,
        ST_BREAK  = 3'd4,
        ST_COMMIT = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_line_meta;
    logic               r_line_s;
    logic               r_busy_d;
    logic [BT_W-1:0]    r_bit_cnt;
    logic [TO_W-1:0]    r_to_cnt;
    logic [7:0]         r_hold;
    logic               r_ena_kill;
    logic               r_err_frame;
    logic               r_err_overrun;
    logic               r_err_timeout;
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [7:0]         r_dout;

    logic               w_busy_rise;
    logic               w_busy_fall;
    logic               w_hold_load;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_set_frame;
    logic               w_set_overrun;
    logic               w_set_timeout;
    logic               w_bit_clr;
    logic [PTR_W-1:0]   w_rd_next;
    logic [CNT_W-1:0]   w_count_next;

    assign w_busy_rise  = rx_busy & ~r_busy_d;
    assign w_busy_fall  = ~rx_busy & r_busy_d;
    assign w_full       = (r_count == CNT_FULL);
    assign w_pop        = (r_count != '0) & dout_ready;
    assign w_rd_next    = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    // A low line in BREAK restarts the run of high samples.
    assign w_bit_clr    = (w_state_next != r_state) ||
                          ((r_state == ST_BREAK) && !r_line_s);

    // Two-flop synchroniser for the raw line plus busy edge history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line_meta <= 1'b1;
            r_line_s    <= 1'b1;
            r_busy_d    <= 1'b0;
        end else begin
            r_line_meta <= rx_line;
            r_line_s    <= r_line_meta;
            r_busy_d    <= rx_busy;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state and per-state event decode.
    always_comb begin
        w_state_next  = r_state;
        w_hold_load   = 1'b0;
        w_push        = 1'b0;
        w_set_frame   = 1'b0;
        w_set_overrun = 1'b0;
        w_set_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Only arm on a high line so we never start mid-frame.
                if (enable && r_line_s) w_state_next = ST_ARM;
            end
            ST_ARM: begin
                if (!enable)          w_state_next = ST_IDLE;
                else if (w_busy_rise) w_state_next = ST_RECV;
            end
            ST_RECV: begin
                // enable is ignored here: a started frame always completes.
                if (w_busy_fall) begin
                    w_hold_load  = 1'b1;
                    w_state_next = ST_STOP;
                end else if (r_to_cnt == TO_LAST) begin
                    w_set_timeout = 1'b1;
                    w_state_next  = ST_ARM;
                end
            end
            ST_STOP: begin
                if (r_bit_cnt == BT_HALF_M1) begin
                    if (r_line_s) begin
                        w_state_next = ST_COMMIT;
                    end else begin
                        w_set_frame  = 1'b1;
                        w_state_next = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (r_line_s && (r_bit_cnt == BT_LAST))
                    w_state_next = enable ? ST_ARM : ST_IDLE;
            end
            ST_COMMIT: begin
                if (w_full) w_set_overrun = 1'b1;
                else        w_push        = 1'b1;
                w_state_next = enable ? ST_ARM : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Bit timer and RECV timeout counter, both restarted on state entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_to_cnt  <= '0;
        end else begin
            if (w_bit_clr || (r_bit_cnt == BT_LAST)) r_bit_cnt <= '0;
            else                                     r_bit_cnt <= r_bit_cnt + 1'b1;
            if ((r_state == ST_RECV) && (w_state_next == ST_RECV))
                r_to_cnt <= r_to_cnt + 1'b1;
            else
                r_to_cnt <= '0;
        end
    end

    // Frame byte capture and the one-cycle datapath kill after a timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold     <= '0;
            r_ena_kill <= 1'b0;
        end else begin
            if (w_hold_load) r_hold <= rx_data;
            r_ena_kill <= w_set_timeout;
        end
    end

    // Sticky error flags; a new event wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_frame   <= 1'b0;
            r_err_overrun <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_err_frame   <= w_set_frame   | (r_err_frame   & ~err_clr);
            r_err_overrun <= w_set_overrun | (r_err_overrun & ~err_clr);
            r_err_timeout <= w_set_timeout | (r_err_timeout & ~err_clr);
        end
    end

    // FIFO storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= r_hold;
    end

    // FIFO pointers, occupancy and registered head byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            // New head is the pushed byte when it lands where the read
            // pointer is heading; an empty FIFO keeps the last dout.
            if (w_count_next != '0) begin
                if (w_push && (w_rd_next == r_wr_ptr)) r_dout <= r_hold;
                else                                   r_dout <= r_mem[w_rd_next];
            end
        end
    end

`ifdef UART_RX_CTRL_STATS_EN
    logic [15:0] r_frames_ok;
    logic [15:0] r_frames_bad;

    // Saturating good/bad frame counters, untouched by err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frames_ok  <= '0;
            r_frames_bad <= '0;
        end else begin
            if (w_push && (r_frames_ok != 16'hFFFF))
                r_frames_ok <= r_frames_ok + 16'd1;
            if ((w_set_frame || w_set_timeout || w_set_overrun) &&
                (r_frames_bad != 16'hFFFF))
                r_frames_bad <= r_frames_bad + 16'd1;
        end
    end

    assign frames_ok  = r_frames_ok;
    assign frames_bad = r_frames_bad;
`endif

    assign rx_ena      = (r_state != ST_IDLE) && !r_ena_kill;
    assign dout        = r_dout;
    assign dout_valid  = (r_count != '0);
    assign fifo_count  = r_count;
    assign err_frame   = r_err_frame;
    assign err_overrun = r_err_overrun;
    assign err_timeout = r_err_timeout;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: the datapath is modelled by driving
// rx_busy/rx_data/rx_line directly; expected bytes live in exp_q.
module tb_uart_rx_ctrl;

  localparam int BIT_CLKS = 434;
  localparam int DEPTH    = 4;
  localparam int TO_LIMIT = 12 * BIT_CLKS;
  localparam int HALF     = BIT_CLKS / 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ARM    = 3'd1;
  localparam logic [2:0] ST_RECV   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
  localparam logic [2:0] ST_BREAK  = 3'd4;
  localparam logic [2:0] ST_COMMIT = 3'd5;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       rx_line;
  logic       rx_busy;
  logic [7:0] rx_data;
  logic       rx_ena;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [2:0] fifo_count;
  logic       err_frame;
  logic       err_overrun;
  logic       err_timeout;
  logic       err_clr;
  logic [2:0] dbg_state;
`ifdef UART_RX_CTRL_STATS_EN
  logic [15:0] frames_ok;
  logic [15:0] frames_bad;
`endif

  int checks = 0;
  int errors = 0;
  int m_ok   = 0;
  int m_bad  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  uart_rx_ctrl #(.BIT_CLKS(BIT_CLKS), .FIFO_DEPTH(DEPTH), .TIMEOUT_BITS(12)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .rx_line     (rx_line),
    .rx_busy     (rx_busy),
    .rx_data     (rx_data),
    .rx_ena      (rx_ena),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .fifo_count  (fifo_count),
    .err_frame   (err_frame),
    .err_overrun (err_overrun),
    .err_timeout (err_timeout),
    .err_clr     (err_clr),
`ifdef UART_RX_CTRL_STATS_EN
    .frames_ok   (frames_ok),
    .frames_bad  (frames_bad),
`endif
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (dbg_state !== s && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (dbg_state !== s) begin
      errors++;
      $display("FAIL %s: state got %0d exp %0d after %0d clks", name, dbg_state, s, n);
    end
  endtask

  // driver tasks
  task automatic start_frame();
    wait_state(ST_ARM, 2000, "wait_arm");
    rx_line = 1'b0;
    rx_busy = 1'b1;
    tick(1);
  endtask

  task automatic finish_frame(input logic [7:0] b);
    tick(8);
    rx_data = b;
    rx_busy = 1'b0;
    rx_line = 1'b1;
    wait_state(ST_COMMIT, 400, "wait_commit");
  endtask

  // Good frame with dout_ready low; updates the scoreboard model.
  task automatic send_good(input logic [7:0] b);
    start_frame();
    finish_frame(b);
    if (exp_q.size() < DEPTH) begin
      exp_q.push_back(b);
      m_ok++;
    end else begin
      m_bad++;
    end
    tick(1);
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick(3);
    checks++;
    if (rx_ena !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_ctrl: rx_ena %b state %0d exp 0 0", rx_ena, dbg_state);
    end
    checks++;
    if (dout !== 8'h00 || dout_valid !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_fifo: dout %h valid %b count %0d exp 00 0 0", dout, dout_valid, fifo_count);
    end
    checks++;
    if ({err_frame, err_overrun, err_timeout} !== 3'b000) begin
      errors++;
      $display("FAIL reset_err: got %b exp 000", {err_frame, err_overrun, err_timeout});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    checks++;
    if (rx_ena !== 1'b1) begin
      errors++;
      $display("FAIL arm_rx_ena: got %b exp 1", rx_ena);
    end
  endtask

  task automatic test_single();
    start_frame();
    finish_frame(8'hA5);
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early: dout_valid got %b exp 0", dout_valid);
    end
    tick(1);
    exp_q.push_back(8'hA5);
    m_ok++;
    checks++;
    if (dout_valid !== 1'b1 || dout !== 8'hA5 || fifo_count !== 3'd1) begin
      errors++;
      $display("FAIL single_byte: dout %h valid %b count %0d exp a5 1 1", dout, dout_valid, fifo_count);
    end
    dout_ready = 1'b1;
    exp_b = exp_q.pop_front();
    tick(1);
    dout_ready = 1'b0;
    checks++;
    if (dout_valid !== 1'b0 || dout !== exp_b) begin
      errors++;
      $display("FAIL single_hold: dout %h valid %b exp %h 0", dout, dout_valid, exp_b);
    end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) send_good(8'(i));
    checks++;
    if (fifo_count !== 3'd4 || err_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun: count %0d err %b exp 4 1", fifo_count, err_overrun);
    end
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_b = exp_q.pop_front();
      checks++;
      if (dout_valid !== 1'b1 || dout !== exp_b) begin
        errors++;
        $display("FAIL drain_%0d: dout %h valid %b exp %h 1", i, dout, dout_valid, exp_b);
      end
      tick(1);
    end
    dout_ready = 1'b0;
    checks++;
    if (dout_valid !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL drain_empty: valid %b count %0d exp 0 0", dout_valid, fifo_count);
    end
    clear_errors();
    checks++;
    if (err_overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clr: got %b exp 0", err_overrun);
    end
  endtask

  task automatic test_frame_error();
    start_frame();
    tick(8);
    rx_data = 8'hEE;
    rx_busy = 1'b0;
    wait_state(ST_STOP, 20, "wait_stop");
    tick(HALF - 1);
    // clear arrives in the same cycle as the stop sample
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    m_bad++;
    checks++;
    if (err_frame !== 1'b1 || dbg_state !== ST_BREAK || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL frame_err: err %b state %0d count %0d exp 1 4 0", err_frame, dbg_state, fifo_count);
    end
    tick(20);
    rx_line = 1'b1;
    tick(200);
    rx_line = 1'b0;
    tick(1);
    rx_line = 1'b1;
    tick(BIT_CLKS);
    checks++;
    if (dbg_state !== ST_BREAK) begin
      errors++;
      $display("FAIL break_restart: state %0d exp 4", dbg_state);
    end
    wait_state(ST_ARM, 10, "break_exit");
    send_good(8'h3C);
    checks++;
    if (dout !== 8'h3C || fifo_count !== 3'd1 || err_frame !== 1'b1) begin
      errors++;
      $display("FAIL after_break: dout %h count %0d err %b exp 3c 1 1", dout, fifo_count, err_frame);
    end
    dout_ready = 1'b1;
    void'(exp_q.pop_front());
    tick(1);
    dout_ready = 1'b0;
    clear_errors();
  endtask

  task automatic test_timeout();
    wait_state(ST_ARM, 10, "to_arm");
    rx_busy = 1'b1;
    tick(1);
    checks++;
    if (dbg_state !== ST_RECV) begin
      errors++;
      $display("FAIL to_recv: state %0d exp 2", dbg_state);
    end
    tick(TO_LIMIT - 1);
    checks++;
    if (err_timeout !== 1'b0 || dbg_state !== ST_RECV) begin
      errors++;
      $display("FAIL to_early: err %b state %0d exp 0 2", err_timeout, dbg_state);
    end
    tick(1);
    m_bad++;
    checks++;
    if (err_timeout !== 1'b1 || rx_ena !== 1'b0 || dbg_state !== ST_ARM) begin
      errors++;
      $display("FAIL to_fire: err %b ena %b state %0d exp 1 0 1", err_timeout, rx_ena, dbg_state);
    end
    tick(1);
    checks++;
    if (rx_ena !== 1'b1) begin
      errors++;
      $display("FAIL to_ena_back: got %b exp 1", rx_ena);
    end
    rx_busy = 1'b0;
    clear_errors();
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_clr: got %b exp 0", err_timeout);
    end
  endtask

  task automatic test_enable_drop();
    start_frame();
    enable = 1'b0;
    tick(5);
    checks++;
    if (dbg_state !== ST_RECV || rx_ena !== 1'b1) begin
      errors++;
      $display("FAIL en_defer: state %0d ena %b exp 2 1", dbg_state, rx_ena);
    end
    finish_frame(8'h5A);
    tick(1);
    exp_q.push_back(8'h5A);
    m_ok++;
    checks++;
    if (dbg_state !== ST_IDLE || rx_ena !== 1'b0 || fifo_count !== 3'd1 || dout !== 8'h5A) begin
      errors++;
      $display("FAIL en_idle: state %0d ena %b count %0d dout %h exp 0 0 1 5a",
               dbg_state, rx_ena, fifo_count, dout);
    end
`ifdef UART_RX_CTRL_STATS_EN
    checks++;
    if (frames_ok !== 16'(m_ok) || frames_bad !== 16'(m_bad)) begin
      errors++;
      $display("FAIL stats_pre: ok %0d bad %0d exp %0d %0d", frames_ok, frames_bad, m_ok, m_bad);
    end
`endif
  endtask

  task automatic test_reset_mid();
    enable = 1'b1;
    start_frame();
    tick(3);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    m_ok  = 0;
    m_bad = 0;
    checks++;
    if (rx_ena !== 1'b0 || dbg_state !== ST_IDLE || fifo_count !== 3'd0 ||
        dout_valid !== 1'b0 || dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: ena %b state %0d count %0d valid %b dout %h exp 0 0 0 0 00",
               rx_ena, dbg_state, fifo_count, dout_valid, dout);
    end
    rx_busy = 1'b0;
    rx_line = 1'b1;
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_push_pop();
    send_good(8'h11);
    send_good(8'h22);
    start_frame();
    finish_frame(8'h33);
    dout_ready = 1'b1;
    exp_b = exp_q.pop_front();
    checks++;
    if (dout !== exp_b || fifo_count !== 3'd2) begin
      errors++;
      $display("FAIL pp_before: dout %h count %0d exp %h 2", dout, fifo_count, exp_b);
    end
    tick(1);
    dout_ready = 1'b0;
    exp_q.push_back(8'h33);
    m_ok++;
    checks++;
    if (fifo_count !== 3'd2 || dout !== exp_q[0]) begin
      errors++;
      $display("FAIL pp_after: count %0d dout %h exp 2 %h", fifo_count, dout, exp_q[0]);
    end
    dout_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_b = exp_q.pop_front();
      checks++;
      if (dout_valid !== 1'b1 || dout !== exp_b) begin
        errors++;
        $display("FAIL pp_drain_%0d: dout %h valid %b exp %h 1", i, dout, dout_valid, exp_b);
      end
      tick(1);
    end
    dout_ready = 1'b0;
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL pp_empty: valid %b exp 0", dout_valid);
    end
`ifdef UART_RX_CTRL_STATS_EN
    checks++;
    if (frames_ok !== 16'(m_ok) || frames_bad !== 16'(m_bad)) begin
      errors++;
      $display("FAIL stats_post: ok %0d bad %0d exp %0d %0d", frames_ok, frames_bad, m_ok, m_bad);
    end
`endif
  endtask

  initial begin
    rst_n      = 1'b1;
    enable     = 1'b1;
    rx_line    = 1'b1;
    rx_busy    = 1'b0;
    rx_data    = 8'h00;
    dout_ready = 1'b0;
    err_clr    = 1'b0;
    test_reset();
    test_single();
    test_overrun();
    test_frame_error();
    test_timeout();
    test_enable_drop();
    test_reset_mid();
    test_push_pop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
